seq_booth_mult_rv: RTL and testbench

//  Sequential signed (two's-complement) multiplier using radix-2 Booth recoding, one step per clock.
//  A valid/ready handshake sits on the operand input side and on the product output side.
//  The block is an internal controller + datapath pair behind one top-level wrapper.
//  It is used wherever a low-area WIDTH x WIDTH -> 2*WIDTH multiply can tolerate about WIDTH cycles of latency.

---
 rtl/seq_booth_mult_pkg.sv | 13 +
 rtl/seq_booth_mult_if.sv | 28 ++
 rtl/seq_booth_mult_ctrl.sv | 75 +++++++
 rtl/seq_booth_mult_rv.sv | 81 ++++++++
 tb/tb_seq_booth_mult_rv.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_booth_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package seq_booth_mult_pkg;

  // Default operand width; the product is twice this.
  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/seq_booth_mult_if.sv
// Operand/product valid-ready bundle for the Booth multiplier.
interface seq_booth_mult_if
  import seq_booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic                 src_valid;
  logic                 src_ready;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 dest_valid;
  logic                 dest_ready;
  logic [2*WIDTH-1:0]   Product;

  // Requester side: issues operands, consumes the product.
  modport master (
    output src_valid, Multiplicand, Multiplier, dest_ready,
    input  src_ready, dest_valid, Product
  );

  // Multiplier side.
  modport slave (
    input  src_valid, Multiplicand, Multiplier, dest_ready,
    output src_ready, dest_valid, Product
  );

endinterface

// File: rtl/seq_booth_mult_ctrl.sv
// Controller for the Booth multiplier: Moore FSM plus the step counter.
module seq_booth_mult_ctrl
  import seq_booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_valid,
  input  logic                       dest_ready,
  input  logic                       cnt_last,
  output logic                       load,
  output logic                       step,
  output logic                       latch,
  output logic                       src_ready,
  output logic                       dest_valid,
  output logic [$clog2(WIDTH)-1:0]   count
);

  state_t state_q;
  // Set once the final Booth step has been issued; the next CALC cycle latches the product.
  logic   fin_q;

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count      <= '0;
      fin_q      <= 1'b0;
      src_ready  <= 1'b1;
      dest_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (src_valid) begin
            state_q   <= CALC;
            count     <= '0;
            fin_q     <= 1'b0;
            src_ready <= 1'b0;
          end
        end
        CALC: begin
          if (fin_q) begin
            state_q    <= DONE;
            fin_q      <= 1'b0;
            dest_valid <= 1'b1;
          end else begin
            count <= count + 1'b1;
            if (cnt_last) fin_q <= 1'b1;
          end
        end
        DONE: begin
          if (dest_ready) begin
            state_q    <= IDLE;
            dest_valid <= 1'b0;
            src_ready  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          src_ready  <= 1'b1;
          dest_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes decoded from the registered state.
  always_comb begin
    load  = (state_q == IDLE) && src_valid;
    step  = (state_q == CALC) && !fin_q;
    latch = (state_q == CALC) && fin_q;
  end

endmodule

// File: rtl/seq_booth_mult_rv.sv
// Sequential signed radix-2 Booth multiplier with valid/ready on both sides.
module seq_booth_mult_rv
  import seq_booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic             clk,
  input logic             reset,
  seq_booth_mult_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic            load;
  logic            step;
  logic            latch;
  logic            cnt_last;
  logic [CntW-1:0] count;

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH:0]     a_q;
  logic [WIDTH-1:0]   q_q;
  logic               q1_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     sum;

  assign cnt_last    = (count == CntW'(WIDTH - 1));
  assign bus.Product = prod_q;

  seq_booth_mult_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (bus.src_valid),
    .dest_ready (bus.dest_ready),
    .cnt_last   (cnt_last),
    .load       (load),
    .step       (step),
    .latch      (latch),
    .src_ready  (bus.src_ready),
    .dest_valid (bus.dest_valid),
    .count      (count)
  );

  // Booth recode of {Q[0],Q_1}; A carries one guard bit so M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    unique case ({q_q[0], q1_q})
      2'b10:   sum = a_q - m_ext;
      2'b01:   sum = a_q + m_ext;
      default: sum = a_q;
    endcase
  end

  // Operand load, arithmetic right shift of {A,Q,Q_1}, and product capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      q1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      if (load) begin
        m_q  <= bus.Multiplicand;
        q_q  <= bus.Multiplier;
        a_q  <= '0;
        q1_q <= 1'b0;
      end else if (step) begin
        a_q  <= {sum[WIDTH], sum[WIDTH:1]};
        q_q  <= {sum[0], q_q[WIDTH-1:1]};
        q1_q <= q_q[0];
      end
      if (latch) prod_q <= {a_q[WIDTH-1:0], q_q};
    end
  end

endmodule

// File: tb/tb_seq_booth_mult_rv.sv
// Directed-vector and random bench for seq_booth_mult_rv.
module tb_seq_booth_mult_rv;

  localparam int unsigned W = 16;
  localparam int          Latency = 17;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  seq_booth_mult_if #(.WIDTH(W)) bus ();

  seq_booth_mult_rv #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // One full transaction; result captured when dest_valid first appears.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int stall,
                        input bit rnd_ready, output logic [31:0] res, output int lat,
                        output logic rdy_after);
    int guard;
    @(negedge clk);
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    bus.src_valid    = 1'b1;
    bus.dest_ready   = 1'b0;
    guard = 0;
    while (!bus.src_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.src_valid    = 1'b0;
    bus.Multiplicand = ~m;
    bus.Multiplier   = ~q;
    lat = 0;
    while (!bus.dest_valid && lat < 100) begin
      if (rnd_ready) bus.dest_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    bus.dest_ready = 1'b0;
    res = bus.Product;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    bus.dest_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dest_ready = 1'b0;
    rdy_after = bus.src_ready;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] exp_p;
    logic [15:0] rm;
    logic [15:0] rq;
    logic        rdy;
    logic        bad;
    int          lat;

    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{"3x5",        16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{"-3x5",       16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    vecs[2] = '{"-1x-1",      16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[3] = '{"max x max",  16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[4] = '{"min x min",  16'h8000, 16'h8000, 32'h40000000};
    vecs[5] = '{"min x max",  16'h8000, 16'h7FFF, 32'hC0008000};
    vecs[6] = '{"0 x 1234",   16'h0000, 16'h1234, 32'h00000000};
    vecs[7] = '{"5 x -3",     16'h0005, 16'hFFFD, 32'hFFFFFFF1};

    reset            = 1'b0;
    bus.src_valid    = 1'b0;
    bus.dest_ready   = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Product", 64'(bus.Product), 64'h0);
    check("reset dest_valid", 64'(bus.dest_valid), 64'h0);
    check("reset src_ready", 64'(bus.src_ready), 64'h1);
    reset = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].q, 0, 1'b0, res, lat, rdy);
      check({vecs[i].name, " product"}, 64'(res), 64'(vecs[i].p));
      check({vecs[i].name, " latency"}, 64'(lat), 64'(Latency));
      check({vecs[i].name, " src_ready after"}, 64'(rdy), 64'h1);
    end

    // Backpressure: 3 x 5 held in DONE for 10 cycles.
    @(negedge clk);
    bus.Multiplicand = 16'd3;
    bus.Multiplier   = 16'd5;
    bus.src_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
    lat = 0;
    while (!bus.dest_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("backpressure hold", {bus.dest_valid, bus.src_ready, bus.Product},
            {1'b1, 1'b0, 32'h0000000F});
    end
    bus.dest_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dest_ready = 1'b0;
    check("backpressure release", {bus.dest_valid, bus.src_ready}, {1'b0, 1'b1});
    check("product held after transfer", 64'(bus.Product), 64'h0000000F);

    // Operand and src_valid churn during CALC must not disturb the result.
    @(negedge clk);
    bus.Multiplicand = 16'h0011;
    bus.Multiplier   = 16'hFFFE;
    bus.src_valid    = 1'b1;
    @(posedge clk);
    #1;
    bad = 1'b0;
    lat = 0;
    while (!bus.dest_valid && lat < 100) begin
      bus.Multiplicand = 16'($urandom);
      bus.Multiplier   = 16'($urandom);
      bus.src_valid    = 1'($urandom_range(0, 1));
      if (bus.src_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.src_valid = 1'b0;
    check("churn product", 64'(bus.Product), 64'hFFFFFFDE);
    check("churn latency", 64'(lat), 64'(Latency));
    check("churn no accept", 64'(bad), 64'h0);
    bus.dest_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dest_ready = 1'b0;

    // Reset asserted at CALC step 8 aborts the operation.
    @(negedge clk);
    bus.Multiplicand = 16'h1234;
    bus.Multiplier   = 16'h0056;
    bus.src_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset Product", 64'(bus.Product), 64'h0);
    check("mid reset dest_valid", 64'(bus.dest_valid), 64'h0);
    check("mid reset src_ready", 64'(bus.src_ready), 64'h1);
    reset = 1'b1;
    run_op(16'd6, 16'd7, 0, 1'b0, res, lat, rdy);
    check("6x7 after reset", 64'(res), 64'h0000002A);
    check("6x7 latency", 64'(lat), 64'(Latency));

    // Random signed pairs with random stalls and dest_ready noise during CALC.
    for (int k = 0; k < 1000; k++) begin
      rm    = 16'($urandom);
      rq    = 16'($urandom);
      exp_p = $signed({{16{rm[15]}}, rm}) * $signed({{16{rq[15]}}, rq});
      run_op(rm, rq, int'($urandom_range(0, 3)), 1'b1, res, lat, rdy);
      check("random product", 64'(res), 64'(exp_p));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
